// File: rtl/knn_pkg.sv
// Shared k-NN types: candidate/neighbour entry layout and the default coordinate/distance width.
package knn_pkg;

  localparam int KNN_B = 32;

  typedef struct packed {
    logic             valid;
    logic [KNN_B-1:0] distance;
    logic [KNN_B-1:0] x;
    logic [KNN_B-1:0] y;
    logic [KNN_B-1:0] z;
  } knn_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } topk_state_e;

endpackage

// File: rtl/topk_slot.sv
// One sorted-buffer slot: holds an entry, flags whether the candidate sorts after it, and
// on insert either holds, shifts in the previous slot's entry, or loads the candidate (1-cycle update).
module topk_slot
  import knn_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       insert,
  input  knn_entry_t cand,
  input  knn_entry_t prev_entry,
  input  logic       prev_le,
  output knn_entry_t entry,
  output logic       le
);

  // "<=" places equal distances ahead of the candidate, keeping insertion stable.
  assign le = entry.valid && (entry.distance <= cand.distance);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry <= '0;
    end else if (clear) begin
      entry <= '0;
    end else if (insert && !le) begin
      entry <= prev_le ? cand : prev_entry;
    end
  end

endmodule

// File: rtl/topk_insert_buffer.sv
// Top-K nearest-neighbour buffer: sorted single-cycle insert during FILL, then an in-order drain.
// Candidates accepted only in FILL; drain advances one slot per out_valid/out_ready handshake.
module topk_insert_buffer
  import knn_pkg::*;
#(
  parameter int K = 8,
  parameter int B = KNN_B
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  knn_entry_t             in_entry,
  input  logic                   in_not_taken,
  input  logic                   in_valid_comp,
  input  logic                   in_last,
  output logic                   in_ready,
  output knn_entry_t             out_entry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [B-1:0]           kth_distance,
  output logic [$clog2(K+1)-1:0] count,
  output logic                   done
);

  localparam int CW = $clog2(K+1);
  localparam int PW = $clog2(K);

  topk_state_e   state_q, state_d;
  knn_entry_t    slots      [K];
  knn_entry_t    prev_entry [K];
  logic [K-1:0]  le;
  logic [K-1:0]  prev_le;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          accept;
  logic          do_insert;
  logic          hs;

  assign full         = slots[K-1].valid;
  assign kth_distance = full ? B'(slots[K-1].distance) : '1;
  assign in_ready     = (state_q == ST_FILL);
  assign accept       = in_ready && in_valid_comp && !start;
  // le[K-1] on a full buffer means the candidate is no better than the worst held entry.
  assign do_insert    = accept && in_not_taken && in_entry.valid && !le[K-1];

  assign out_entry = slots[rd_ptr];
  assign out_valid = (state_q == ST_DRAIN) && (count != '0);
  assign out_last  = out_valid && (CW'(rd_ptr) == count - CW'(1));
  assign hs        = out_valid && out_ready;
  assign done      = (state_q == ST_DRAIN) && !start && ((count == '0) || (hs && out_last));

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prev_entry[i] = '0;
      assign prev_le[i]    = 1'b1;
    end else begin : g_body
      assign prev_entry[i] = slots[i-1];
      assign prev_le[i]    = le[i-1];
    end

    topk_slot u_slot (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear      (start),
      .insert     (do_insert),
      .cand       (in_entry),
      .prev_entry (prev_entry[i]),
      .prev_le    (prev_le[i]),
      .entry      (slots[i]),
      .le         (le[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL:  if (accept && in_last) state_d = ST_DRAIN;
        ST_DRAIN: if (done) state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
    end else if (start) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_insert && (count != CW'(K))) begin
        count <= count + CW'(1);
      end
      if (state_q != ST_DRAIN) begin
        rd_ptr <= '0;
      end else if (hs) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_topk_insert_buffer.sv
// Directed bench for topk_insert_buffer (K=4): expected drain entries are queued as stimulus is issued
// and a negedge monitor pops and compares on every output handshake.
module tb_topk_insert_buffer;
  import knn_pkg::*;

  localparam int K = 4;

  logic         clock;
  logic         reset_n;
  logic         start;
  knn_entry_t   in_entry;
  logic         in_not_taken;
  logic         in_valid_comp;
  logic         in_last;
  logic         in_ready;
  knn_entry_t   out_entry;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [31:0]  kth_distance;
  logic [2:0]   count;
  logic         done;

  typedef struct {
    logic [31:0] d;
    logic [31:0] tag;
    logic        last;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  topk_insert_buffer #(.K(K), .B(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .in_entry      (in_entry),
    .in_not_taken  (in_not_taken),
    .in_valid_comp (in_valid_comp),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .out_entry     (out_entry),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .kth_distance  (kth_distance),
    .count         (count),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] tag, input logic last);
    exp_t e;
    e.d    = d;
    e.tag  = tag;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] tag, input logic nt,
                      input logic v, input logic last);
    in_entry      = '{valid: v, distance: d, x: tag, y: 32'd0, z: 32'd0};
    in_not_taken  = nt;
    in_valid_comp = 1'b1;
    in_last       = last;
    @(posedge clock); #1;
    in_valid_comp = 1'b0;
    in_last       = 1'b0;
    in_not_taken  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int i;
    i = 0;
    while (done_cnt < n && i < 40) begin
      @(posedge clock); #1;
      i++;
    end
    chk("done_count", done_cnt, n);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_in_ready", in_ready, 0);
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual_dist=%0d required=none", out_entry.distance);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_dist", out_entry.distance, mon_e.d);
          chk("out_tag", out_entry.x, mon_e.tag);
          chk("out_last", out_last, mon_e.last);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    in_entry      = '0;
    in_not_taken  = 1'b0;
    in_valid_comp = 1'b0;
    in_last       = 1'b0;
    out_ready     = 1'b1;
    #3;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_kth", kth_distance, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic sorted insert with overflow on the final candidate.
    do_start();
    chk("fill_in_ready", in_ready, 1);
    send(50, 50, 1, 1, 0);
    send(20, 20, 1, 1, 0);
    send(80, 80, 1, 1, 0);
    send(10, 10, 1, 1, 0);
    chk("t1_count", count, 4);
    chk("t1_kth", kth_distance, 80);
    push_exp(10, 10, 0);
    push_exp(20, 20, 0);
    push_exp(30, 30, 0);
    push_exp(50, 50, 1);
    send(30, 30, 1, 1, 1);
    wait_done(1);

    // Rejected candidates only: empty drain.
    do_start();
    send(5, 5, 0, 1, 0);
    send(6, 6, 1, 0, 0);
    chk("t2_count", count, 0);
    chk("t2_kth", kth_distance, 32'hFFFF_FFFF);
    send(7, 7, 0, 1, 1);
    wait_done(2);

    // Full buffer: equal-to-kth dropped, smaller inserted; drain under backpressure.
    do_start();
    send(10, 10, 1, 1, 0);
    send(20, 20, 1, 1, 0);
    send(30, 30, 1, 1, 0);
    send(40, 40, 1, 1, 0);
    chk("t3_full_count", count, 4);
    chk("t3_full_kth", kth_distance, 40);
    send(40, 41, 1, 1, 0);
    chk("t3_drop_count", count, 4);
    chk("t3_drop_kth", kth_distance, 40);
    send(15, 15, 1, 1, 0);
    chk("t3_ins_kth", kth_distance, 30);
    chk("t3_ins_count", count, 4);
    out_ready = 1'b0;
    push_exp(10, 10, 0);
    push_exp(15, 15, 0);
    push_exp(20, 20, 0);
    push_exp(30, 30, 1);
    send(99, 99, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall0_valid", out_valid, 1);
      chk("t3_stall0_dist", out_entry.distance, 10);
      chk("t3_stall0_last", out_last, 0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall1_dist", out_entry.distance, 15);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    wait_done(3);

    // Equal distances drain in arrival order.
    do_start();
    push_exp(25, 32'hA, 0);
    push_exp(25, 32'hB, 1);
    send(25, 32'hA, 1, 1, 0);
    send(25, 32'hB, 1, 1, 1);
    wait_done(4);

    // Reset in the middle of a drain, then a fresh query.
    out_ready = 1'b0;
    do_start();
    send(10, 10, 1, 1, 0);
    send(20, 20, 1, 1, 1);
    chk("t5_drain_valid", out_valid, 1);
    chk("t5_drain_dist", out_entry.distance, 10);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_count", count, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_last", out_last, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_kth", kth_distance, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("t5_no_done", done_cnt, 4);
    out_ready = 1'b1;
    do_start();
    push_exp(7, 7, 1);
    send(7, 7, 1, 1, 1);
    wait_done(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/topk_insert_buffer.md
TOPK_INSERT_BUFFER -- requirements
Module: topk_insert_buffer

Interface
REQ-001 SHALL have parameter K, default 8: number of neighbour slots, 2..32.
REQ-002 SHALL have parameter B, default 32: distance and coordinate bit width.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse that clears the buffer and opens a new query.
REQ-006 SHALL have port in_entry  input  knn_entry_t: candidate point (valid, distance, x, y, z) from the comparator stage.
REQ-007 SHALL have port in_not_taken  input  1: comparator flag; high means distance < running mean.
REQ-008 SHALL have port in_valid_comp  input  1: comparator qualifier; candidate is meaningful this cycle.
REQ-009 SHALL have port in_last  input  1: marks the final candidate of the query.
REQ-010 SHALL have port in_ready  output  1: buffer accepts a candidate this cycle.
REQ-011 SHALL have port out_entry  output  knn_entry_t: drained neighbour.
REQ-012 SHALL have port out_valid  output  1, and port out_ready  input  1: drain handshake.
REQ-013 SHALL have port out_last  output  1: marks the final drained neighbour.
REQ-014 SHALL have port kth_distance  output  B: worst held distance, all-ones when not full.
REQ-015 SHALL have port count  output  $clog2(K+1): occupied slots.
REQ-016 SHALL have port done  output  1: one-cycle pulse when the drain completes.

Function
REQ-017 SHALL implement states IDLE, FILL, DRAIN.
REQ-018 SHALL move from IDLE to FILL on start, clearing all slots and count.
REQ-019 SHALL, on start in any state, clear and enter FILL; start has priority over every other event.
REQ-020 SHALL drive in_ready=1 only in FILL.
REQ-021 SHALL treat a candidate as accepted when in_ready and in_valid_comp are high; in_last is sampled only on accepted cycles.
REQ-022 SHALL discard an accepted candidate when in_not_taken=0, in_entry.valid=0, or the buffer is full and distance >= kth_distance.
REQ-023 SHALL otherwise insert the candidate in ascending-distance order in the same cycle, shifting larger entries down one slot; when full, the slot K-1 entry is dropped.
REQ-024 SHALL place a new entry after existing entries of equal distance (stable order).
REQ-025 SHALL increment count on insert when not full; count saturates at K.
REQ-026 SHALL update kth_distance combinationally from registered slot K-1, reflecting each insert the cycle after it.
REQ-027 SHALL enter DRAIN the cycle after an accepted in_last, applying that candidate's insert first.
REQ-028 SHALL, in DRAIN, present slots 0..count-1 in order, advancing one slot per out_valid&&out_ready cycle.
REQ-029 SHALL assert out_last with the final slot, pulse done on its handshake, and return to IDLE.
REQ-030 SHALL, in DRAIN with count=0, emit no out_valid, pulse done, and return to IDLE in one cycle.
REQ-031 SHALL hold out_entry stable while out_valid=1 and out_ready=0.
REQ-032 SHALL use an unsigned distance compare over the full B bits.

Reset
REQ-033 SHALL, on reset_n low, set state=IDLE, count=0, all slot valid bits=0, out_valid=0, out_last=0, done=0, in_ready=0, kth_distance=all-ones.
REQ-034 SHALL, on reset mid-FILL or mid-DRAIN, abandon the query, with no done pulse.

Structure
REQ-035 SHALL take knn_entry_t and the B default from the shared knn_pkg package; K is local.
REQ-036 SHALL use one sub-module, topk_slot, instantiated K times: it holds one entry, compares it against the candidate, and selects hold, shift-in-previous, or load-candidate.

Verification
REQ-037 SHALL cover (K=4): start; insert distances 50,20,80,10, then 30 with last -> drain 10,20,30,50 with out_last on 50, then done.
REQ-038 SHALL cover (K=4): candidates with in_not_taken=0 or in_entry.valid=0 -> count stays 0; last -> done with no out_valid.
REQ-039 SHALL cover (K=4): full at 10,20,30,40; candidate 40 -> dropped; candidate 15 -> contents 10,15,20,30 and kth_distance=30.
REQ-040 SHALL cover ties: insert 25(A) then 25(B) -> drain order A before B.
REQ-041 SHALL cover backpressure: out_ready low for 3 cycles mid-drain -> out_entry held; no duplicates and no skips.
REQ-042 SHALL cover reset: reset_n low mid-DRAIN -> all REQ-033 values, no done; start then resumes a normal query.
